dtw_job_sequencer: RTL and testbench

Sequences the `dtw_core` datapath through complete jobs (reference load or query) from a single command handshake. It replaces direct software toggling of the control-register bits: it drives core reset, run/start, mode and reference length, and supervises busy/load_done/sink-empty. It reports a one-cycle completion with status and cycle count. It sits between the AXI-Lite register file and `dtw_core` in the `i_axi_clk` domain.

---
 rtl/dtw_pkg.sv | 29 ++
 rtl/dtw_seq_timer.sv | 27 ++
 rtl/dtw_job_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_dtw_job_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW job sequencer: FSM states, status codes, op codes
// and a small elaboration-time helper.
package dtw_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } seq_state_e;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_START_TO = 2'b01;
  localparam logic [1:0] ST_RUN_TO   = 2'b10;
  localparam logic [1:0] ST_ABORT    = 2'b11;

  localparam logic OP_QUERY = 1'b0;
  localparam logic OP_LOAD  = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dtw_seq_timer.sv
// Loadable down-counter shared by the reset/error hold and both job timeouts.
// The count stops at zero; expired is high while it sits there.
module dtw_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/dtw_job_sequencer.sv
// Runs dtw_core through a full reference-load or query job from one command
// handshake, supervising start/run timeouts and abort, and reports status.
module dtw_job_sequencer
  import dtw_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int START_TIMEOUT = 64,
  parameter int RUN_TIMEOUT   = 1 << 20,
  parameter int LEN_WIDTH     = 32
) (
  input  logic                 i_axi_clk,
  input  logic                 i_axi_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_op,
  input  logic [LEN_WIDTH-1:0] i_cmd_ref_len,
  input  logic                 i_abort,
  output logic                 o_core_rst,
  output logic                 o_core_rs,
  output logic                 o_core_mode,
  output logic [LEN_WIDTH-1:0] o_ref_len,
  input  logic                 i_core_busy,
  input  logic                 i_core_load_done,
  input  logic                 i_sink_empty,
  output logic                 o_done,
  output logic [1:0]           o_status,
  output logic [31:0]          o_job_cycles,
  output logic                 o_active
);

  localparam int TMAX = max3(RUN_TIMEOUT, START_TIMEOUT, RST_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  // The timer counts down to zero and the FSM leaves on the zero edge, so an
  // N-cycle dwell loads N-1.
  localparam logic [TW-1:0] RST_LOAD   = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] START_LOAD = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] RUN_LOAD   = TW'(RUN_TIMEOUT - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  seq_state_e     state;
  seq_state_e     state_nxt;
  logic           accept;
  logic [1:0]     err_code;
  logic           err_entry;
  logic           counting;
  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_expired;

  dtw_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk      (i_axi_clk),
    .rst_n    (i_axi_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort is tested first, then the completion/progress condition, and the
  // timeout last, so completion beats timeout and abort beats both.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_code  = ST_OK;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      S_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          accept    = 1'b1;
          state_nxt = S_RESET;
        end
      end
      S_RESET: begin
        if (i_abort) begin
          state_nxt = S_ERR;
          err_code  = ST_ABORT;
        end else if (tmr_expired) begin
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (i_abort) begin
          state_nxt = S_ERR;
          err_code  = ST_ABORT;
        end else if (i_core_busy || (o_core_mode == OP_LOAD && i_core_load_done)) begin
          state_nxt = S_RUN;
        end else if (tmr_expired) begin
          state_nxt = S_ERR;
          err_code  = ST_START_TO;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_nxt = S_ERR;
          err_code  = ST_ABORT;
        end else if (o_core_mode == OP_LOAD) begin
          if (i_core_load_done) begin
            state_nxt = S_DONE;
          end else if (tmr_expired) begin
            state_nxt = S_ERR;
            err_code  = ST_RUN_TO;
          end
        end else if (!i_core_busy) begin
          state_nxt = S_DRAIN;
        end else if (tmr_expired) begin
          state_nxt = S_ERR;
          err_code  = ST_RUN_TO;
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          state_nxt = S_ERR;
          err_code  = ST_ABORT;
        end else if (i_sink_empty) begin
          state_nxt = S_DONE;
        end else if (tmr_expired) begin
          state_nxt = S_ERR;
          err_code  = ST_RUN_TO;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (tmr_expired) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // DRAIN deliberately keeps the RUN budget running.
    if (state_nxt != state) begin
      case (state_nxt)
        S_RESET, S_ERR: begin
          tmr_load = 1'b1;
          tmr_val  = RST_LOAD;
        end
        S_ARM: begin
          tmr_load = 1'b1;
          tmr_val  = START_LOAD;
        end
        S_RUN: begin
          tmr_load = 1'b1;
          tmr_val  = RUN_LOAD;
        end
        default: begin
          tmr_load = 1'b0;
        end
      endcase
    end
  end

  assign err_entry = (state_nxt == S_ERR) && (state != S_ERR);
  assign counting  = (state == S_RESET) || (state == S_ARM) ||
                     (state == S_RUN)   || (state == S_DRAIN);

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      o_cmd_ready  <= 1'b1;
      o_active     <= 1'b0;
      o_core_rst   <= 1'b0;
      o_core_rs    <= 1'b0;
      o_core_mode  <= OP_QUERY;
      o_ref_len    <= '0;
      o_done       <= 1'b0;
      o_status     <= ST_OK;
      o_job_cycles <= '0;
    end else begin
      o_cmd_ready <= (state_nxt == S_IDLE);
      o_active    <= (state_nxt != S_IDLE);
      o_core_rst  <= (state_nxt == S_RESET) || (state_nxt == S_ERR);
      o_core_rs   <= (state_nxt == S_ARM) || (state_nxt == S_RUN);
      o_done      <= (state_nxt == S_DONE) || err_entry;
      if (accept) begin
        o_core_mode  <= i_cmd_op;
        o_ref_len    <= i_cmd_ref_len;
        o_status     <= ST_OK;
        o_job_cycles <= '0;
      end else begin
        if (counting) begin
          o_job_cycles <= sat_inc(o_job_cycles);
        end
        if (err_entry) begin
          o_status <= err_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_dtw_job_sequencer.sv
// Scoreboard bench for dtw_job_sequencer: per-job input timelines, a phase-level
// reference model, and a monitor that checks every completion report.
module tb_dtw_job_sequencer;
  import dtw_pkg::*;

  localparam int R  = 4;
  localparam int ST = 64;
  localparam int RT = 200;
  localparam int LW = 32;
  localparam int TL = 400;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_op = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          busy = 1'b0;
  logic          ld = 1'b0;
  logic          se = 1'b1;
  logic          cmd_ready, core_rst, core_rs, core_mode, done, active;
  logic [LW-1:0] ref_len;
  logic [1:0]    status;
  logic [31:0]   job_cycles;

  always #5 clk = ~clk;

  dtw_job_sequencer #(
    .RST_CYCLES    (R),
    .START_TIMEOUT (ST),
    .RUN_TIMEOUT   (RT),
    .LEN_WIDTH     (LW)
  ) dut (
    .i_axi_clk        (clk),
    .i_axi_rst        (rst_n),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_op         (cmd_op),
    .i_cmd_ref_len    (cmd_len),
    .i_abort          (abort),
    .o_core_rst       (core_rst),
    .o_core_rs        (core_rs),
    .o_core_mode      (core_mode),
    .o_ref_len        (ref_len),
    .i_core_busy      (busy),
    .i_core_load_done (ld),
    .i_sink_empty     (se),
    .o_done           (done),
    .o_status         (status),
    .o_job_cycles     (job_cycles),
    .o_active         (active)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]    st;
    int            cyc;
    logic          op;
    logic [LW-1:0] len;
  } exp_t;

  exp_t sb[$];

  // Input timeline per job, indexed by edge number after the accept edge.
  bit bz_tl[TL];
  bit ld_tl[TL];
  bit se_tl[TL];
  bit ab_tl[TL];

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("status", status, x.st);
        chk("job_cycles", job_cycles, x.cyc);
        chk("mode_at_done", core_mode, x.op);
        chk("ref_len_at_done", ref_len, x.len);
      end
    end
  end

  // Start edge k into ARM (0 = never). Query: busy for b edges, sink empty s
  // edges after busy drops. Load: load_done from the start edge onward.
  task automatic build(input logic op, input int k, input int b, input int s, input int ab_t);
    for (int t = 0; t < TL; t++) begin
      bz_tl[t] = 1'b0;
      ld_tl[t] = 1'b0;
      se_tl[t] = 1'b0;
      ab_tl[t] = 1'b0;
    end
    if (k > 0) begin
      for (int t = R + k; t < TL; t++) begin
        if (op) begin
          ld_tl[t] = 1'b1;
        end else begin
          if (t < R + k + b) bz_tl[t] = 1'b1;
          if (t >= R + k + b + s) se_tl[t] = 1'b1;
        end
      end
    end
    if (ab_t > 0 && ab_t < TL) ab_tl[ab_t] = 1'b1;
  endtask

  // Job outcome from the phase rules: reset hold, start window, shared run budget.
  function automatic void predict(input logic op, output logic [1:0] st, output int e);
    int  rs;
    bit  drn;
    for (int t = 1; t <= R; t++) begin
      if (ab_tl[t]) begin
        st = ST_ABORT;
        e  = t;
        return;
      end
    end
    rs = 0;
    for (int t = R + 1; t <= R + ST; t++) begin
      if (ab_tl[t]) begin
        st = ST_ABORT;
        e  = t;
        return;
      end
      if (bz_tl[t] || (op && ld_tl[t])) begin
        rs = t;
        break;
      end
    end
    if (rs == 0) begin
      st = ST_START_TO;
      e  = R + ST;
      return;
    end
    drn = 1'b0;
    for (int t = rs + 1; t <= rs + RT; t++) begin
      if (ab_tl[t]) begin
        st = ST_ABORT;
        e  = t;
        return;
      end
      if (drn) begin
        if (se_tl[t]) begin
          st = ST_OK;
          e  = t;
          return;
        end
      end else if (op) begin
        if (ld_tl[t]) begin
          st = ST_OK;
          e  = t;
          return;
        end
      end else if (!bz_tl[t]) begin
        drn = 1'b1;
      end
    end
    st = ST_RUN_TO;
    e  = rs + RT;
  endfunction

  // Called at a negedge with the sequencer idle; returns at the negedge where
  // it is idle again.
  task automatic run_job(input logic op, input logic [LW-1:0] len);
    logic [1:0] st;
    int         e;
    int         rdy_t;
    exp_t       x;
    predict(op, st, e);
    rdy_t = (st == ST_OK) ? e + 2 : e + R + 1;
    x.st = st;
    x.cyc = e;
    x.op = op;
    x.len = len;
    sb.push_back(x);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    @(posedge clk);
    for (int t = 1; t <= rdy_t; t++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (t == 1) begin
        chk("mode_latched", core_mode, op);
        chk("ref_len_latched", ref_len, len);
        chk("active", active, 1);
      end
      if (e > R && t <= R) chk("core_rst_hold", core_rst, 1);
      if (e > R && t == R + 1) begin
        chk("core_rst_fall", core_rst, 0);
        chk("core_rs_rise", core_rs, 1);
      end
      if (t == e) chk("done_early", done, 0);
      if (t == e + 1) chk("done_pulse", done, 1);
      if (st != ST_OK && t == e + R) chk("err_rst_hold", core_rst, 1);
      if (t == rdy_t - 1) chk("ready_low", cmd_ready, 0);
      if (t == rdy_t) begin
        chk("ready_back", cmd_ready, 1);
        chk("status_held", status, st);
        chk("cycles_held", job_cycles, e);
        chk("core_rst_idle", core_rst, 0);
      end
      if (t <= e) begin
        busy  = bz_tl[t];
        ld    = ld_tl[t];
        se    = se_tl[t];
        abort = ab_tl[t];
      end else begin
        busy  = 1'b0;
        ld    = 1'b0;
        se    = 1'b1;
        abort = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_core_rst"}, core_rst, 0);
    chk({tag, "_core_rs"}, core_rs, 0);
    chk({tag, "_mode"}, core_mode, 0);
    chk({tag, "_ref_len"}, ref_len, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_cycles"}, job_cycles, 0);
    chk({tag, "_active"}, active, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    build(OP_LOAD, 10, 0, 0, 0);             run_job(OP_LOAD, 32'd123);
    build(OP_LOAD, 1, 0, 0, 0);              run_job(OP_LOAD, 32'd7);
    build(OP_QUERY, 3, 100, 5, 0);           run_job(OP_QUERY, 32'd4000);
    build(OP_QUERY, 0, 0, 0, 0);             run_job(OP_QUERY, 32'd55);
    build(OP_QUERY, 2, 1000, 1, 0);          run_job(OP_QUERY, 32'd66);
    build(OP_QUERY, 2, 50, 3, R + 2 + 50);   run_job(OP_QUERY, 32'd77);
    build(OP_LOAD, ST, 0, 0, 0);             run_job(OP_LOAD, 32'd88);
    build(OP_QUERY, 1, 150, 50, 0);          run_job(OP_QUERY, 32'd99);
    build(OP_QUERY, 1, 150, 51, 0);          run_job(OP_QUERY, 32'd100);
    build(OP_LOAD, 5, 0, 0, 2);              run_job(OP_LOAD, 32'd101);
    build(OP_LOAD, 5, 0, 0, R + 6);          run_job(OP_LOAD, 32'd102);

    for (int j = 0; j < 30; j++) begin
      logic op;
      int   k, b, s, ab_t;
      op   = logic'($urandom_range(0, 1));
      k    = $urandom_range(1, ST + 8);
      b    = $urandom_range(1, 150);
      s    = $urandom_range(1, 60);
      ab_t = ($urandom_range(0, 3) == 0) ? $urandom_range(1, R + k + b + s) : 0;
      build(op, k, b, s, ab_t);
      run_job(op, $urandom);
    end

    // Asynchronous reset in the middle of a query job.
    cmd_valid = 1'b1;
    cmd_op    = OP_QUERY;
    cmd_len   = 32'd4321;
    @(posedge clk);
    for (int t = 1; t <= R + 6; t++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      busy      = 1'b1;
      se        = 1'b0;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk);
    busy  = 1'b0;
    se    = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    build(OP_LOAD, 1, 0, 0, 0);
    run_job(OP_LOAD, 32'd2024);

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
